// File: rtl/osc_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_mon_pkg
// Brief    : Shared encodings for the oscillator frequency monitor: FSM state
//            codes and the default edge-count width.
// Revision : 1.0  initial release
// ============================================================================
package osc_mon_pkg;

    // Default width of the reported edge count (saturating)
    localparam int c_CNT_W = 16;

    // Measurement FSM state encoding
    localparam int               c_ST_W       = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_ARM     = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_MEASURE = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_REPORT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/osc_mon_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : osc_mon_edge_sync
// Brief    : Brings the asynchronous monitored clock into the fabric clock
//            domain (two-flop synchronizer) and produces a one-cycle pulse on
//            each synchronized rising edge using a history flop.
// Revision : 1.0  initial release
// ============================================================================
module osc_mon_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic mon_in,
    output logic edge_det
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Synchronizer pair plus history flop; all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= mon_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Rising edge of the synchronized signal, high for exactly one cycle
    assign edge_det = r_sync2 & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : osc_freq_monitor
// Brief    : Counts rising edges of an asynchronous monitored clock over a
//            fixed gate window, reports the count with an in-range flag, and
//            flags an oscillator that has stopped toggling.
// Revision : 1.0  initial release
// ============================================================================
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES = 50000,
    parameter int EXPECT        = 1000,
    parameter int TOL           = 10,
    parameter int STUCK_CYCLES  = 200,
    parameter int CNT_W         = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             in_range,
    output logic             stuck
);

    localparam int c_WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int c_IDLE_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [c_WIN_W-1:0]  c_WIN_LAST  = c_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_STUCK_SAT = c_IDLE_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    // Range bounds carry one extra bit so EXPECT+TOL may exceed the count
    // range without wrapping; the lower bound clamps at zero.
    localparam logic [CNT_W:0] c_RANGE_LO = (EXPECT > TOL) ? (CNT_W+1)'(EXPECT - TOL) : '0;
    localparam logic [CNT_W:0] c_RANGE_HI = (CNT_W+1)'(EXPECT + TOL);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_next;
    logic                w_arm;
    logic                w_measure;
    logic                w_report;
    logic                w_busy;
    logic                w_win_last;
    logic                w_edge;
    logic                w_in_range;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_IDLE_W-1:0] w_idle_next;
    logic                r_stuck;
    logic                r_valid;
    logic [CNT_W-1:0]    r_count;
    logic                r_in_range;

    osc_mon_edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .mon_in   (mon_in),
        .edge_det (w_edge)
    );

    assign w_win_last = (r_win_cnt == c_WIN_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: START only honoured from IDLE, CONT only looked at in REPORT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (start) w_state_next = c_ST_ARM;
            c_ST_ARM:     w_state_next = c_ST_MEASURE;
            c_ST_MEASURE: if (w_win_last) w_state_next = c_ST_REPORT;
            c_ST_REPORT:  w_state_next = cont ? c_ST_ARM : c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_arm     = (r_state == c_ST_ARM);
        w_measure = (r_state == c_ST_MEASURE);
        w_report  = (r_state == c_ST_REPORT);
        w_busy    = (r_state != c_ST_IDLE);
    end

    // Gate-window counter: cleared in ARM, counts every MEASURE cycle
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_win_cnt <= '0;
        end else if (w_measure) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    // Edge counter: cleared in ARM, saturating count of edges during MEASURE
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_edge_cnt <= '0;
        end else if (w_measure && w_edge && (r_edge_cnt != c_CNT_MAX)) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    // Idle-time next value: an edge wins over the saturating increment
    always_comb begin
        w_idle_next = r_idle_cnt;
        if (w_edge) begin
            w_idle_next = '0;
        end else if (r_idle_cnt != c_STUCK_SAT) begin
            w_idle_next = r_idle_cnt + 1'b1;
        end
    end

    // Free-running stuck detector, independent of the measurement FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_stuck    <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_next;
            r_stuck    <= (w_idle_next == c_STUCK_SAT);
        end
    end

    assign w_in_range = ({1'b0, r_edge_cnt} >= c_RANGE_LO) &&
                        ({1'b0, r_edge_cnt} <= c_RANGE_HI);

    // Result registers: captured in REPORT, held until the next REPORT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_in_range <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (w_report) begin
                r_count    <= r_edge_cnt;
                r_in_range <= w_in_range;
            end
        end
    end

    assign busy     = w_busy;
    assign valid    = r_valid;
    assign count    = r_count;
    assign in_range = r_in_range;
    assign stuck    = r_stuck;

endmodule
`default_nettype wire
